// File: rtl/error_injection_sequencer.sv
// Error-injection bus master: steps err_ctrl through a run of consecutive codes,
// holding each for a dwell and separating codes with an optional quiet gap.
module error_injection_sequencer #(
  parameter int CTRL_W  = 16,
  parameter int DWELL_W = 16,
  parameter int GAP_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CTRL_W-1:0]  cmd_first,
  input  logic [CTRL_W-1:0]  cmd_count,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [GAP_W-1:0]   cmd_gap,
  input  logic               abort,
  output logic               err_en,
  output logic [CTRL_W-1:0]  err_ctrl,
  output logic               busy,
  output logic               done,
  output logic               done_aborted,
  output logic [CTRL_W-1:0]  inj_count
);

  typedef enum logic [1:0] {S_IDLE, S_INJECT, S_GAP} state_t;

  state_t             r_state;
  logic [CTRL_W-1:0]  r_code;
  logic [CTRL_W-1:0]  r_left;
  logic [DWELL_W-1:0] r_dwell_cfg;
  logic [DWELL_W-1:0] r_dwell_left;
  logic [GAP_W-1:0]   r_gap_cfg;
  logic [GAP_W-1:0]   r_gap_left;

  logic               w_active;
  logic               w_inject_end;
  logic               w_gap_end;
  logic               w_abort_end;
  logic               w_normal_end;
  logic               w_to_gap;
  logic               w_advance;
  logic [CTRL_W-1:0]  w_next_code;
  logic [CTRL_W-1:0]  w_inj_inc;
  logic [DWELL_W-1:0] w_dwell_m1;

  assign cmd_ready = (r_state == S_IDLE) && !rst;

  // Counters hold "cycles left after this one", so a dwell of 0 behaves like 1.
  assign w_dwell_m1   = (cmd_dwell == '0) ? '0 : cmd_dwell - DWELL_W'(1);
  assign w_next_code  = r_code + CTRL_W'(1);
  assign w_inj_inc    = (&inj_count) ? inj_count : inj_count + CTRL_W'(1);

  assign w_active     = (r_state != S_IDLE);
  assign w_inject_end = (r_state == S_INJECT) && (r_dwell_left == '0);
  assign w_gap_end    = (r_state == S_GAP) && (r_gap_left == '0);
  assign w_abort_end  = w_active && abort;
  assign w_normal_end = !abort && w_inject_end && (r_left == '0);
  assign w_to_gap     = !abort && w_inject_end && (r_left != '0) && (r_gap_cfg != '0);
  assign w_advance    = !abort && ((w_inject_end && (r_left != '0) && (r_gap_cfg == '0)) || w_gap_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_left       <= '0;
      r_dwell_cfg  <= '0;
      r_dwell_left <= '0;
      r_gap_cfg    <= '0;
      r_gap_left   <= '0;
      err_en       <= 1'b0;
      err_ctrl     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      inj_count    <= '0;
    end else begin
      done <= 1'b0;
      if (w_abort_end || w_normal_end) begin
        r_state      <= S_IDLE;
        err_en       <= 1'b0;
        err_ctrl     <= '0;
        busy         <= 1'b0;
        done         <= 1'b1;
        done_aborted <= w_abort_end;
      end else if (w_to_gap) begin
        r_state    <= S_GAP;
        err_en     <= 1'b0;
        err_ctrl   <= '0;
        r_gap_left <= r_gap_cfg - GAP_W'(1);
      end else if (w_advance) begin
        r_state      <= S_INJECT;
        err_en       <= 1'b1;
        err_ctrl     <= w_next_code;
        r_code       <= w_next_code;
        r_left       <= r_left - CTRL_W'(1);
        r_dwell_left <= r_dwell_cfg;
        inj_count    <= w_inj_inc;
      end else if (r_state == S_INJECT) begin
        r_dwell_left <= r_dwell_left - DWELL_W'(1);
      end else if (r_state == S_GAP) begin
        r_gap_left <= r_gap_left - GAP_W'(1);
      end else if (cmd_valid) begin
        // Idle accept; abort is deliberately not looked at here.
        r_code       <= cmd_first;
        r_dwell_cfg  <= w_dwell_m1;
        r_dwell_left <= w_dwell_m1;
        r_gap_cfg    <= cmd_gap;
        done_aborted <= 1'b0;
        if (cmd_count == '0) begin
          inj_count <= '0;
          done      <= 1'b1;
        end else begin
          r_state   <= S_INJECT;
          r_left    <= cmd_count - CTRL_W'(1);
          err_en    <= 1'b1;
          err_ctrl  <= cmd_first;
          busy      <= 1'b1;
          inj_count <= CTRL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_error_injection_sequencer.sv
// Directed and randomized campaigns checked cycle-by-cycle against a trace
// built from the campaign rules (code run, dwell, gap, abort, done).
module tb_error_injection_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_first;
  logic [15:0] cmd_count;
  logic [15:0] cmd_dwell;
  logic [7:0]  cmd_gap;
  logic        abort;
  logic        err_en;
  logic [15:0] err_ctrl;
  logic        busy;
  logic        done;
  logic        done_aborted;
  logic [15:0] inj_count;

  int n_assert = 0;
  int n_fail   = 0;

  error_injection_sequencer #(.CTRL_W(16), .DWELL_W(16), .GAP_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_first(cmd_first), .cmd_count(cmd_count),
    .cmd_dwell(cmd_dwell), .cmd_gap(cmd_gap),
    .abort(abort),
    .err_en(err_en), .err_ctrl(err_ctrl),
    .busy(busy), .done(done), .done_aborted(done_aborted),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  // Observation vector: {en, ctrl[15:0], busy, done, aborted, inj[15:0], ready}
  function automatic logic [36:0] mk(input logic en, input logic [15:0] ctrl,
                                     input logic b, input logic dn, input logic ab,
                                     input logic [15:0] inj, input logic rdy);
    return {en, ctrl, b, dn, ab, inj, rdy};
  endfunction

  function automatic logic [36:0] obs();
    return {err_en, err_ctrl, busy, done, done_aborted, inj_count, cmd_ready};
  endfunction

  task automatic check(input string tag, input logic [36:0] exp);
    logic [36:0] o;
    o = obs();
    n_assert++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic junk();
    cmd_first = 16'($urandom);
    cmd_count = 16'($urandom_range(1, 50));
    cmd_dwell = 16'($urandom_range(0, 9));
    cmd_gap   = 8'($urandom_range(0, 5));
  endtask

  // Runs one campaign. The expected trace is the list of cycles the rules give:
  // for code i: D cycles of (en=1, first+i), then gap cycles of (en=0) except after the last.
  task automatic campaign(input string tag, input logic [15:0] f, input logic [15:0] c,
                          input logic [15:0] d, input logic [7:0] g, input int abort_at,
                          input bit preissued, input bit chain,
                          input logic [15:0] nf, input logic [15:0] nc,
                          input logic [15:0] nd, input logic [7:0] ng);
    logic [36:0] q[$];
    logic [15:0] inj_q[$];
    logic [15:0] inj;
    logic [15:0] last_inj;
    int          dd;
    bit          ab;
    dd = (d == 16'd0) ? 1 : int'(d);
    for (int i = 0; i < int'(c); i++) begin
      inj = (i + 1 > 65535) ? 16'hFFFF : 16'(i + 1);
      for (int k = 0; k < dd; k++) begin
        q.push_back(mk(1'b1, 16'(int'(f) + i), 1'b1, 1'b0, 1'b0, inj, 1'b0));
        inj_q.push_back(inj);
      end
      if (i < int'(c) - 1)
        for (int k = 0; k < int'(g); k++) begin
          q.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, inj, 1'b0));
          inj_q.push_back(inj);
        end
    end
    last_inj = (c == 16'd0) ? 16'd0 : c;
    if (!preissued) begin
      cmd_valid = 1'b1;
      cmd_first = f;
      cmd_count = c;
      cmd_dwell = d;
      cmd_gap   = g;
      abort     = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = chain;
    if (chain) junk();
    ab = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("%s/cyc%0d", tag, i), q[i]);
      if (i == abort_at) begin
        abort    = 1'b1;
        ab       = 1'b1;
        last_inj = inj_q[i];
      end
      if (chain) junk();
      @(negedge clk);
      if (ab) break;
    end
    abort = 1'b0;
    check({tag, "/done"}, mk(1'b0, 16'd0, 1'b0, 1'b1, ab, last_inj, 1'b1));
    if (chain) begin
      cmd_valid = 1'b1;
      cmd_first = nf;
      cmd_count = nc;
      cmd_dwell = nd;
      cmd_gap   = ng;
    end else begin
      cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, "/post"}, mk(1'b0, 16'd0, 1'b0, 1'b0, ab, last_inj, 1'b1));
    end
  endtask

  initial begin
    logic [15:0] rf, rc, rd;
    logic [7:0]  rg;
    int          len, ab_at, ddr;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_first = '0;
    cmd_count = '0;
    cmd_dwell = '0;
    cmd_gap   = '0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    check("in_reset", 37'd0);
    rst = 1'b0;
    #1;
    check("reset_state", mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1));

    campaign("basic", 16'h0003, 16'd3, 16'd4, 8'd2, -1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0);
    campaign("wrap", 16'hFFFE, 16'd3, 16'd1, 8'd0, -1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0);
    campaign("zero", 16'h1234, 16'd0, 16'd5, 8'd1, -1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0);
    campaign("dwell0", 16'h0010, 16'd2, 16'd0, 8'd1, -1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0);
    // Third code starts at cycle 2*8 + 2*1 = 18; abort two cycles into it.
    campaign("abort", 16'd7, 16'd10, 16'd8, 8'd1, 20, 1'b0, 1'b1, 16'h0100, 16'd2, 16'd2, 8'd1);
    campaign("chained", 16'h0100, 16'd2, 16'd2, 8'd1, -1, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 8'd0);

    // Reset in the middle of a gap.
    cmd_valid = 1'b1;
    cmd_first = 16'h0020;
    cmd_count = 16'd3;
    cmd_dwell = 16'd2;
    cmd_gap   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_gap", mk(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0));
    #2 rst = 1'b1;
    #1 check("rst_async", 37'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release", mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", i), mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1));
    end

    for (int n = 0; n < 10; n++) begin
      rf  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom);
      rc  = 16'($urandom_range(0, 5));
      rd  = 16'($urandom_range(0, 4));
      rg  = 8'($urandom_range(0, 3));
      ddr = (rd == 16'd0) ? 1 : int'(rd);
      len = (rc == 16'd0) ? 0 : int'(rc) * ddr + (int'(rc) - 1) * int'(rg);
      ab_at = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      campaign($sformatf("rnd%0d", n), rf, rc, rd, rg, ab_at, 1'b0, 1'b0,
               16'd0, 16'd0, 16'd0, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/error_injection_sequencer.md
Name:
error_injection_sequencer

Overview:
- Master side of the error-injection control bus: generates the shared err_en / err_ctrl pair that the per-region error routers decode into local error lines.
- Accepts a campaign command over a valid/ready handshake and steps err_ctrl through a run of consecutive target codes.
- Holds each code for a programmable dwell and inserts an optional quiet gap between codes.
- Sits between the test controller (host/UART register block) and the fan-out of routers.

Parameters:
CTRL_W, 16, width of err_ctrl code bus (matches router err_ctrl width)
DWELL_W, 16, width of per-code dwell counter
GAP_W, 8, width of inter-code gap counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer idle, can accept
cmd_first  in  CTRL_W  first target code
cmd_count  in  CTRL_W  number of consecutive codes to inject
cmd_dwell  in  DWELL_W  cycles err_en held high per code (0 treated as 1)
cmd_gap  in  GAP_W  cycles err_en held low between codes
abort  in  1  terminate current campaign
err_en  out  1  injection enable to routers
err_ctrl  out  CTRL_W  target code to routers
busy  out  1  campaign in progress
done  out  1  one-cycle pulse at campaign end
done_aborted  out  1  valid with done: 1 = ended by abort
inj_count  out  CTRL_W  codes injected (dwell started) in current/last campaign

Behaviour:
- Reset (async, any state): IDLE; err_en=0, err_ctrl=0, busy=0, done=0, done_aborted=0, inj_count=0, cmd_ready=1.
- All outputs registered; cmd_ready = (state==IDLE) and not rst.
- FSM states:
  - IDLE: cmd_ready=1, err_en=0, err_ctrl=0.
  - INJECT: err_en=1, err_ctrl=current code.
  - GAP: err_en=0, err_ctrl=0.
- Invariant: err_ctrl is 0 whenever err_en is 0.
- Accept: cmd_valid & cmd_ready at edge k latches all cmd_* fields and clears inj_count.
  - cmd_count=0: no injection; done=1 (done_aborted=0) in cycle k+1; remain IDLE, busy stays 0.
  - cmd_count>0: cycle k+1 enters INJECT with err_ctrl=cmd_first, inj_count=1, busy=1.
- INJECT: held exactly D=max(cmd_dwell,1) cycles. At end:
  - codes remaining and gap>0: GAP for exactly cmd_gap cycles, then INJECT with next code.
  - codes remaining and gap=0: next cycle is INJECT with next code; err_en stays 1 with no low cycle, err_ctrl changes.
  - last code: no trailing gap; next cycle IDLE, err_en=0, busy=0, done=1, done_aborted=0.
- Code increment is modulo 2^CTRL_W: 0xFFFF wraps to 0x0000. inj_count increments at each INJECT entry and saturates at all-ones.
- Total campaign length for N>0 codes: N*D + (N-1)*gap cycles of busy.
- abort:
  - Sampled in INJECT or GAP: next cycle IDLE, err_en=0, err_ctrl=0, done=1, done_aborted=1; inj_count holds its value.
  - In IDLE, abort is ignored, including when coincident with an accept; accept wins.
- cmd_valid while busy: not accepted; inputs are ignored and no state is changed.
- done_aborted is cleared on the next accept, or on the next done with value 0.
- busy=1 exactly when the state is INJECT or GAP.
- rst mid-campaign: outputs go to reset values immediately (asynchronous); no done pulse is generated.

Test Plan:
- Reset, then first=0x0003, count=3, dwell=4, gap=2.
  - err_ctrl=3,3,3,3 (err_en=1), then 0,0 (err_en=0), then 4×4, gap, 4×5.
  - Then done=1 with done_aborted=0, inj_count=3, busy high for 16 cycles.
- first=0xFFFE, count=3, dwell=1, gap=0 -> err_ctrl sequence 0xFFFE, 0xFFFF, 0x0000 on consecutive cycles; err_en continuously 1 for 3 cycles; done next cycle.
- count=0 -> no err_en pulse; done=1 one cycle after accept; busy never asserted.
- dwell=0, count=2, gap=1 -> each code held 1 cycle: en pattern 1,0,1 then done.
- first=7, count=10, dwell=8; assert abort during the 3rd INJECT.
  - err_en=0 the next cycle; done=1 with done_aborted=1, inj_count=3.
  - A new command is accepted on the following cycle.
- Assert rst during a GAP -> all outputs 0 immediately, cmd_ready=1 after rst release, no done pulse.
- cmd_valid held high while busy -> second command is accepted only on the first IDLE cycle, with its fields sampled then.
